planificador_accion: RTL and testbench

PLANIFICADOR_ACCION -- requirements
Module: planificador_accion

---
 rtl/planificador_accion.sv | 189 ++++++++++++++++++
 tb/tb_planificador_accion.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/planificador_accion.sv
// SCAN scheduler for a 4-floor elevator: latches floor requests, tracks the car position
// and issues a registered accion command (00 reposo, 01 llegada, 10 subir, 11 bajar).
//
// state         | meaning
// REPOSO        | idle, no movement, waiting for a request
// SUBIR         | car travelling up
// BAJAR         | car travelling down
// LLEGADA       | stopped at a served floor for T_PARADA cycles
// ESPERA_PUERTA | waiting for the door to close before choosing the next move
module planificador_accion #(
    parameter int unsigned T_PARADA = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] boton_piso,
    input  logic [3:0] sensor_piso,
    input  logic       puerta_cerrada,
    output logic [1:0] accion,
    output logic [1:0] piso_actual,
    output logic [3:0] solicitudes,
    output logic       direccion,
    output logic       error_sensor
);

    typedef enum logic [2:0] {
        REPOSO,
        SUBIR,
        BAJAR,
        LLEGADA,
        ESPERA_PUERTA
    } estado_t;

    localparam logic [1:0] ACC_REPOSO  = 2'b00;
    localparam logic [1:0] ACC_LLEGADA = 2'b01;
    localparam logic [1:0] ACC_SUBIR   = 2'b10;
    localparam logic [1:0] ACC_BAJAR   = 2'b11;
    localparam logic [3:0] CARGA_PARADA = 4'(T_PARADA - 1);

    estado_t    estado;
    logic [3:0] cuenta;

    logic       sensor_multiple;
    logic       sensor_valido;
    logic [1:0] sensor_idx;
    logic       pendiente_encima;
    logic       pendiente_debajo;
    logic       pedido_aqui;
    logic       llamada_sensor;
    logic       llega;
    logic [3:0] borrar;

    function automatic logic [3:0] mascara_encima(input logic [1:0] p);
        case (p)
            2'd0:    mascara_encima = 4'b1110;
            2'd1:    mascara_encima = 4'b1100;
            2'd2:    mascara_encima = 4'b1000;
            default: mascara_encima = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] mascara_debajo(input logic [1:0] p);
        case (p)
            2'd0:    mascara_debajo = 4'b0000;
            2'd1:    mascara_debajo = 4'b0001;
            2'd2:    mascara_debajo = 4'b0011;
            default: mascara_debajo = 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] decodifica(input logic [1:0] p);
        decodifica = 4'b0001 << p;
    endfunction

    assign sensor_multiple = (sensor_piso & (sensor_piso - 4'd1)) != 4'd0;
    assign sensor_valido   = (sensor_piso != 4'd0) && !sensor_multiple;

    always_comb begin
        sensor_idx = 2'd0;
        case (sensor_piso)
            4'b0010: sensor_idx = 2'd1;
            4'b0100: sensor_idx = 2'd2;
            4'b1000: sensor_idx = 2'd3;
            default: sensor_idx = 2'd0;
        endcase
    end

    assign pendiente_encima = |(solicitudes & mascara_encima(piso_actual));
    assign pendiente_debajo = |(solicitudes & mascara_debajo(piso_actual));
    assign pedido_aqui      = solicitudes[piso_actual];
    assign llamada_sensor   = solicitudes[sensor_idx] | boton_piso[sensor_idx];

    // The end floors always stop the car so it can never run past the shaft limits.
    assign llega = sensor_valido &&
                   (((estado == SUBIR) && (llamada_sensor || (sensor_idx == 2'd3))) ||
                    ((estado == BAJAR) && (llamada_sensor || (sensor_idx == 2'd0))));

    // Served floor is cleared after OR-ing in buttons, so the clear beats a same-cycle press.
    always_comb begin
        borrar = 4'b0000;
        if ((estado == REPOSO) && pedido_aqui)
            borrar = decodifica(piso_actual);
        else if (llega)
            borrar = decodifica(sensor_idx);
        else if (estado == LLEGADA)
            borrar = decodifica(piso_actual);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado       <= REPOSO;
            accion       <= ACC_REPOSO;
            piso_actual  <= 2'd0;
            solicitudes  <= 4'b0000;
            direccion    <= 1'b1;
            error_sensor <= 1'b0;
            cuenta       <= 4'd0;
        end else begin
            solicitudes <= (solicitudes | boton_piso) & ~borrar;
            if (sensor_valido)
                piso_actual <= sensor_idx;
            if (sensor_multiple)
                error_sensor <= 1'b1;

            case (estado)
                REPOSO: begin
                    if (pedido_aqui) begin
                        estado <= LLEGADA;
                        accion <= ACC_LLEGADA;
                        cuenta <= CARGA_PARADA;
                    end else if (pendiente_encima) begin
                        estado    <= SUBIR;
                        accion    <= ACC_SUBIR;
                        direccion <= 1'b1;
                    end else if (pendiente_debajo) begin
                        estado    <= BAJAR;
                        accion    <= ACC_BAJAR;
                        direccion <= 1'b0;
                    end
                end

                SUBIR, BAJAR: begin
                    if (llega) begin
                        estado <= LLEGADA;
                        accion <= ACC_LLEGADA;
                        cuenta <= CARGA_PARADA;
                    end
                end

                LLEGADA: begin
                    if (cuenta == 4'd0) begin
                        estado <= ESPERA_PUERTA;
                        accion <= ACC_REPOSO;
                    end else begin
                        cuenta <= cuenta - 4'd1;
                    end
                end

                ESPERA_PUERTA: begin
                    if (puerta_cerrada) begin
                        if (direccion && pendiente_encima) begin
                            estado <= SUBIR;
                            accion <= ACC_SUBIR;
                        end else if (!direccion && pendiente_debajo) begin
                            estado <= BAJAR;
                            accion <= ACC_BAJAR;
                        end else if (pendiente_debajo) begin
                            estado    <= BAJAR;
                            accion    <= ACC_BAJAR;
                            direccion <= 1'b0;
                        end else if (pendiente_encima) begin
                            estado    <= SUBIR;
                            accion    <= ACC_SUBIR;
                            direccion <= 1'b1;
                        end else begin
                            estado <= REPOSO;
                            accion <= ACC_REPOSO;
                        end
                    end
                end

                default: begin
                    estado <= REPOSO;
                    accion <= ACC_REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_planificador_accion.sv
// Bench for planificador_accion: directed scenarios plus randomized travel with a simple car
// model, checked through an expectation queue against an array-based reference model.
module tb_planificador_accion;

    localparam int T_PARADA = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] boton_piso;
    logic [3:0] sensor_piso;
    logic       puerta_cerrada;
    logic [1:0] accion;
    logic [1:0] piso_actual;
    logic [3:0] solicitudes;
    logic       direccion;
    logic       error_sensor;

    always #5 clk = ~clk;

    planificador_accion #(.T_PARADA(T_PARADA)) dut (
        .clk            (clk),
        .reset          (reset),
        .boton_piso     (boton_piso),
        .sensor_piso    (sensor_piso),
        .puerta_cerrada (puerta_cerrada),
        .accion         (accion),
        .piso_actual    (piso_actual),
        .solicitudes    (solicitudes),
        .direccion      (direccion),
        .error_sensor   (error_sensor)
    );

    typedef struct packed {
        logic [1:0] accion;
        logic [1:0] piso;
        logic [3:0] sol;
        logic       dir;
        logic       err;
    } salida_t;

    salida_t cola[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: modo 0 idle, 1 up, 2 down, 3 stopped at floor, 4 waiting for door
    int m_modo;
    bit m_req[4];
    int m_piso;
    bit m_dir;
    bit m_err;
    int m_resta;

    task automatic comparar(input string nombre, input int act, input int esp);
        n_cmp++;
        if (act != esp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nombre, act, esp, $time);
        end
    endtask

    function automatic void modelo_reset();
        m_modo = 0;
        for (int i = 0; i < 4; i++) m_req[i] = 1'b0;
        m_piso  = 0;
        m_dir   = 1'b1;
        m_err   = 1'b0;
        m_resta = 0;
    endfunction

    function automatic void modelo_paso(input logic [3:0] b, input logic [3:0] s, input logic d);
        int unos, idx, servido, sig, p;
        bit arriba, abajo, nuevo;
        unos = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (s[i]) begin unos++; idx = i; end
        servido = -1;
        sig = m_modo;
        p = m_piso;
        arriba = 1'b0;
        abajo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_req[i] && i > p) arriba = 1'b1;
            if (m_req[i] && i < p) abajo = 1'b1;
        end
        case (m_modo)
            0: begin
                if (m_req[p]) begin servido = p; sig = 3; m_resta = T_PARADA; end
                else if (arriba) begin sig = 1; m_dir = 1'b1; end
                else if (abajo) begin sig = 2; m_dir = 1'b0; end
            end
            1, 2: begin
                if (unos == 1 && (m_req[idx] || b[idx] || (m_modo == 1 && idx == 3) ||
                                  (m_modo == 2 && idx == 0))) begin
                    servido = idx;
                    sig = 3;
                    m_resta = T_PARADA;
                end
            end
            3: begin
                m_resta--;
                if (m_resta == 0) sig = 4;
            end
            default: begin
                if (d) begin
                    if (m_dir && arriba) sig = 1;
                    else if (!m_dir && abajo) sig = 2;
                    else if (abajo) begin sig = 2; m_dir = 1'b0; end
                    else if (arriba) begin sig = 1; m_dir = 1'b1; end
                    else sig = 0;
                end
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            nuevo = m_req[i] | b[i];
            if (i == servido) nuevo = 1'b0;
            if (m_modo == 3 && i == p) nuevo = 1'b0;
            m_req[i] = nuevo;
        end
        if (unos == 1) m_piso = idx;
        if (unos > 1) m_err = 1'b1;
        m_modo = sig;
    endfunction

    function automatic salida_t modelo_salida();
        salida_t o;
        case (m_modo)
            1: o.accion = 2'b10;
            2: o.accion = 2'b11;
            3: o.accion = 2'b01;
            default: o.accion = 2'b00;
        endcase
        o.piso = 2'(m_piso);
        for (int i = 0; i < 4; i++) o.sol[i] = m_req[i];
        o.dir = m_dir;
        o.err = m_err;
        return o;
    endfunction

    task automatic ciclo(input logic [3:0] b, input logic [3:0] s, input logic d, input logic r);
        @(negedge clk);
        boton_piso = b;
        sensor_piso = s;
        puerta_cerrada = d;
        reset = r;
        if (r) modelo_reset();
        else modelo_paso(b, s, d);
        cola.push_back(modelo_salida());
        @(posedge clk);
        #2;
    endtask

    task automatic reset_async();
        @(negedge clk);
        boton_piso = 4'b0000;
        sensor_piso = 4'b0000;
        reset = 1'b1;
        modelo_reset();
        cola.push_back(modelo_salida());
        #1;
        comparar("async_accion", accion, 0);
        comparar("async_sol", solicitudes, 0);
        comparar("async_piso", piso_actual, 0);
        comparar("async_err", error_sensor, 0);
        @(posedge clk);
        #2;
    endtask

    always begin
        salida_t esp;
        @(posedge clk);
        #1;
        if (cola.size() != 0) begin
            esp = cola.pop_front();
            comparar("mon_accion", accion, esp.accion);
            comparar("mon_piso", piso_actual, esp.piso);
            comparar("mon_sol", solicitudes, esp.sol);
            comparar("mon_dir", direccion, esp.dir);
            comparar("mon_err", error_sensor, esp.err);
        end
    end

    initial begin
        logic [3:0] glitches[4];
        logic [3:0] uno;
        logic [3:0] b, s;
        logic d, r;
        int pos;
        glitches[0] = 4'b0110;
        glitches[1] = 4'b1100;
        glitches[2] = 4'b0011;
        glitches[3] = 4'b1010;
        uno = 4'b0001;
        reset = 1'b1;
        boton_piso = 4'b0000;
        sensor_piso = 4'b0001;
        puerta_cerrada = 1'b0;
        modelo_reset();

        // Call to floor 2 from floor 0, passing floor 1 without stopping
        repeat (2) ciclo(4'b0000, 4'b0001, 1'b0, 1'b1);
        ciclo(4'b0000, 4'b0001, 1'b0, 1'b0);
        ciclo(4'b0100, 4'b0001, 1'b0, 1'b0);
        comparar("latch_sol", solicitudes, 4'b0100);
        comparar("aun_reposo", accion, 0);
        ciclo(4'b0000, 4'b0001, 1'b0, 1'b0);
        comparar("latencia_subir", accion, 2);
        ciclo(4'b0000, 4'b0000, 1'b0, 1'b0);
        ciclo(4'b0000, 4'b0010, 1'b0, 1'b0);
        comparar("pasa_piso1", accion, 2);
        ciclo(4'b0000, 4'b0000, 1'b0, 1'b0);
        ciclo(4'b0000, 4'b0100, 1'b0, 1'b0);
        comparar("llega_p2", accion, 1);
        comparar("sol_servida", solicitudes, 4'b0000);
        for (int k = 0; k < T_PARADA - 1; k++) begin
            ciclo(4'b0000, 4'b0100, 1'b0, 1'b0);
            comparar("parada", accion, 1);
        end
        ciclo(4'b0000, 4'b0100, 1'b0, 1'b0);
        comparar("fin_parada", accion, 0);
        ciclo(4'b0000, 4'b0100, 1'b1, 1'b0);

        // Idle call at the current floor, then a press of that floor while stopped
        ciclo(4'b0100, 4'b0100, 1'b1, 1'b0);
        ciclo(4'b0000, 4'b0100, 1'b1, 1'b0);
        comparar("llegada_directa", accion, 1);
        ciclo(4'b0100, 4'b0100, 1'b1, 1'b0);
        comparar("descarta_pulso", solicitudes, 4'b0000);
        repeat (3) ciclo(4'b0000, 4'b0100, 1'b1, 1'b0);
        repeat (2) ciclo(4'b0000, 4'b0100, 1'b1, 1'b0);
        comparar("sin_segunda_parada", accion, 0);

        // SCAN: serve floor 3 first, then reverse toward floor 0
        ciclo(4'b1001, 4'b0100, 1'b0, 1'b0);
        ciclo(4'b0000, 4'b0100, 1'b0, 1'b0);
        comparar("scan_sube", accion, 2);
        ciclo(4'b0000, 4'b0000, 1'b0, 1'b0);
        ciclo(4'b0000, 4'b1000, 1'b0, 1'b0);
        comparar("llega_p3", accion, 1);
        comparar("pendiente_p0", solicitudes, 4'b0001);
        repeat (T_PARADA) ciclo(4'b0000, 4'b1000, 1'b0, 1'b0);
        ciclo(4'b0000, 4'b1000, 1'b1, 1'b0);
        comparar("invierte", accion, 3);
        comparar("dir_baja", direccion, 0);
        ciclo(4'b0000, 4'b0100, 1'b0, 1'b0);
        ciclo(4'b0000, 4'b0000, 1'b0, 1'b0);
        ciclo(4'b1010, 4'b0000, 1'b0, 1'b0);
        comparar("sol_pendientes", solicitudes, 4'b1011);
        ciclo(4'b0000, 4'b0110, 1'b0, 1'b0);
        comparar("err_sensor", error_sensor, 1);
        comparar("piso_retenido", piso_actual, 2);
        ciclo(4'b0000, 4'b0000, 1'b0, 1'b0);
        comparar("err_pegajoso", error_sensor, 1);
        reset_async();
        ciclo(4'b0000, 4'b0001, 1'b0, 1'b0);
        comparar("post_reset_sol", solicitudes, 0);

        // Randomized travel: car position advances only while the model says it is moving
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            b = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            s = (pos % 3 == 0) ? (uno << (pos / 3)) : 4'b0000;
            if ($urandom_range(0, 99) == 0) s = glitches[$urandom_range(0, 3)];
            d = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 499) == 0);
            ciclo(b, s, d, r);
            if (m_modo == 1 && pos < 9 && $urandom_range(0, 1) == 1) pos++;
            else if (m_modo == 2 && pos > 0 && $urandom_range(0, 1) == 1) pos--;
        end

        repeat (2) @(posedge clk);
        #3;
        comparar("cola_vacia", cola.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
